// File: rtl/ram_arbiter_if.sv
// dualport_bus: single-read/single-write RAM bus with immediate grants and
// read data returned one cycle after the read grant.
interface dualport_bus #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_gnt;
    logic [DW-1:0]   rd_data;
    logic            wr_req;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_be;
    logic            wr_gnt;
    modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    input  rd_gnt, rd_data, wr_gnt);
    modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
                    output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one dualport_bus RAM between fetch (m0) and load/store (m1).
// Optional RAM_ARB_RAW_BYPASS_EN forwards same-cycle same-word write bytes into the returned read data.
module ram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst,
    dualport_bus.slave  m0,
    dualport_bus.slave  m1,
    dualport_bus.master s,
    output logic        m0_rd_valid,
    output logic        m1_rd_valid
);
    logic          r_rd_last, r_wr_last, r_rd_pend, r_rd_owner;
    logic          w_rd_win, w_wr_win, w_rd_go, w_wr_go;
    logic [AW-1:0] w_rd_addr, w_wr_addr;
    logic [DW-1:0] w_rd_data;

    // win = 1 selects m1; r_*_last = 1 means m1 held the previous grant
    assign w_rd_win  = m1.rd_req & (~m0.rd_req | ~r_rd_last);
    assign w_wr_win  = m1.wr_req & (~m0.wr_req | ~r_wr_last);
    assign w_rd_addr = w_rd_win ? m1.rd_addr : m0.rd_addr;
    assign w_wr_addr = w_wr_win ? m1.wr_addr : m0.wr_addr;

    assign s.rd_req  = m0.rd_req | m1.rd_req;
    assign s.rd_addr = w_rd_addr;
    assign s.wr_req  = m0.wr_req | m1.wr_req;
    assign s.wr_addr = w_wr_addr;
    assign s.wr_data = w_wr_win ? m1.wr_data : m0.wr_data;
    assign s.wr_be   = w_wr_win ? m1.wr_be : m0.wr_be;

    assign w_rd_go   = s.rd_req & s.rd_gnt;
    assign w_wr_go   = s.wr_req & s.wr_gnt;
    assign m0.rd_gnt = w_rd_go & ~w_rd_win;
    assign m1.rd_gnt = w_rd_go & w_rd_win;
    assign m0.wr_gnt = w_wr_go & ~w_wr_win;
    assign m1.wr_gnt = w_wr_go & w_wr_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_last  <= 1'b1;
            r_wr_last  <= 1'b1;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_go;
            if (w_rd_go) begin
                r_rd_last  <= w_rd_win;
                r_rd_owner <= w_rd_win;
            end
            if (w_wr_go)
                r_wr_last <= w_wr_win;
        end
    end

`ifdef RAM_ARB_RAW_BYPASS_EN
    logic            r_byp;
    logic [DW-1:0]   r_byp_data;
    logic [DW/8-1:0] r_byp_be;

    always_ff @(posedge clk) begin
        if (rst)
            r_byp <= 1'b0;
        else
            r_byp <= w_rd_go & w_wr_go & (w_rd_addr[AW-1:2] == w_wr_addr[AW-1:2]);
        r_byp_data <= s.wr_data;
        r_byp_be   <= s.wr_be;
    end

    for (genvar i = 0; i < DW/8; i++) begin : g_byp
        assign w_rd_data[8*i +: 8] = (r_byp & r_byp_be[i]) ? r_byp_data[8*i +: 8] : s.rd_data[8*i +: 8];
    end
`else
    assign w_rd_data = s.rd_data;
`endif

    assign m0.rd_data = w_rd_data;
    assign m1.rd_data = w_rd_data;
    // a read pending across reset must never surface as valid
    assign m0_rd_valid = r_rd_pend & ~rst & ~r_rd_owner;
    assign m1_rd_valid = r_rd_pend & ~rst & r_rd_owner;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model of arbitration, read return and RAM contents.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic m0_rd_valid, m1_rd_valid;
    int   vec = 0;
    int   err = 0;

    dualport_bus bm0 ();
    dualport_bus bm1 ();
    dualport_bus bs ();

    ram_arbiter dut (
        .clk(clk), .rst(rst), .m0(bm0), .m1(bm1), .s(bs),
        .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid)
    );

    always #5 clk = ~clk;

    // downstream RAM: immediate grants, 1-cycle read, old data on collision
    logic [31:0] ram [256];
    assign bs.rd_gnt = 1'b1;
    assign bs.wr_gnt = 1'b1;
    always @(posedge clk) begin
        if (bs.rd_req)
            bs.rd_data <= ram[bs.rd_addr[9:2]];
        if (bs.wr_req)
            for (int i = 0; i < 4; i++)
                if (bs.wr_be[i])
                    ram[bs.wr_addr[9:2]][8*i +: 8] <= bs.wr_data[8*i +: 8];
    end

    // reference model: who was served last (1 = m1), pending return, memory image
    bit          m_rd_last, m_wr_last, m_pend, m_owner;
    logic [31:0] m_data;
    logic [31:0] mem [256];

    function automatic logic [31:0] init_word(int i);
        return {8'(i), 8'(255 - i), 8'(i * 7), 8'(i ^ 8'h5a)};
    endfunction

    task automatic idle();
        bm0.rd_req = 0; bm0.rd_addr = '0; bm0.wr_req = 0; bm0.wr_addr = '0; bm0.wr_data = '0; bm0.wr_be = '0;
        bm1.rd_req = 0; bm1.rd_addr = '0; bm1.wr_req = 0; bm1.wr_addr = '0; bm1.wr_data = '0; bm1.wr_be = '0;
    endtask

    task automatic run_cycle();
        int          rw, ww;
        logic [31:0] ra, wa, wd;
        logic [3:0]  wb;
        rw = (bm0.rd_req && bm1.rd_req) ? (m_rd_last ? 0 : 1) : bm0.rd_req ? 0 : bm1.rd_req ? 1 : -1;
        ww = (bm0.wr_req && bm1.wr_req) ? (m_wr_last ? 0 : 1) : bm0.wr_req ? 0 : bm1.wr_req ? 1 : -1;
        ra = (rw == 1) ? bm1.rd_addr : bm0.rd_addr;
        wa = (ww == 1) ? bm1.wr_addr : bm0.wr_addr;
        wd = (ww == 1) ? bm1.wr_data : bm0.wr_data;
        wb = (ww == 1) ? bm1.wr_be : bm0.wr_be;
        #1;
        if (!rst) begin
            vec++; if (bm0.rd_gnt !== (rw == 0)) begin err++; $display("FAIL m0_rd_gnt: got %b want %b", bm0.rd_gnt, rw == 0); end
            vec++; if (bm1.rd_gnt !== (rw == 1)) begin err++; $display("FAIL m1_rd_gnt: got %b want %b", bm1.rd_gnt, rw == 1); end
            vec++; if (bm0.wr_gnt !== (ww == 0)) begin err++; $display("FAIL m0_wr_gnt: got %b want %b", bm0.wr_gnt, ww == 0); end
            vec++; if (bm1.wr_gnt !== (ww == 1)) begin err++; $display("FAIL m1_wr_gnt: got %b want %b", bm1.wr_gnt, ww == 1); end
            vec++; if (bs.rd_req !== (rw >= 0)) begin err++; $display("FAIL s_rd_req: got %b want %b", bs.rd_req, rw >= 0); end
            vec++; if (bs.wr_req !== (ww >= 0)) begin err++; $display("FAIL s_wr_req: got %b want %b", bs.wr_req, ww >= 0); end
            if (rw >= 0) begin
                vec++; if (bs.rd_addr !== ra) begin err++; $display("FAIL s_rd_addr: got %h want %h", bs.rd_addr, ra); end
            end
            if (ww >= 0) begin
                vec++;
                if (bs.wr_addr !== wa || bs.wr_data !== wd || bs.wr_be !== wb) begin
                    err++;
                    $display("FAIL s_wr_bus: got %h/%h/%b want %h/%h/%b", bs.wr_addr, bs.wr_data, bs.wr_be, wa, wd, wb);
                end
            end
        end
        vec++; if (m0_rd_valid !== (m_pend && !rst && !m_owner)) begin err++; $display("FAIL m0_rd_valid: got %b want %b", m0_rd_valid, m_pend && !rst && !m_owner); end
        vec++; if (m1_rd_valid !== (m_pend && !rst && m_owner)) begin err++; $display("FAIL m1_rd_valid: got %b want %b", m1_rd_valid, m_pend && !rst && m_owner); end
        if (m_pend && !rst) begin
            vec++; if (bm0.rd_data !== m_data) begin err++; $display("FAIL m0_rd_data: got %h want %h", bm0.rd_data, m_data); end
            vec++; if (bm1.rd_data !== m_data) begin err++; $display("FAIL m1_rd_data: got %h want %h", bm1.rd_data, m_data); end
        end
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_rd_last = 1; m_wr_last = 1;
        end else begin
            m_pend = (rw >= 0);
            if (rw >= 0) begin
                m_owner   = (rw == 1);
                m_rd_last = (rw == 1);
                m_data    = mem[ra[9:2]];
`ifdef RAM_ARB_RAW_BYPASS_EN
                if (ww >= 0 && ra[31:2] == wa[31:2])
                    for (int i = 0; i < 4; i++)
                        if (wb[i]) m_data[8*i +: 8] = wd[8*i +: 8];
`endif
            end
            if (ww >= 0) begin
                m_wr_last = (ww == 1);
                for (int i = 0; i < 4; i++)
                    if (wb[i]) mem[wa[9:2]][8*i +: 8] = wd[8*i +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; run_cycle(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; run_cycle(); run_cycle(); rst = 0;
        #1;
        vec++; if (m0_rd_valid !== 0 || m1_rd_valid !== 0) begin err++; $display("FAIL reset_valid: got %b%b want 00", m0_rd_valid, m1_rd_valid); end
        vec++; if (bs.rd_req !== 0 || bs.wr_req !== 0) begin err++; $display("FAIL reset_idle_req: got %b%b want 00", bs.rd_req, bs.wr_req); end
        run_cycle(); run_cycle();
    endtask

    task automatic test_single_read();
        idle(); bm0.rd_req = 1; bm0.rd_addr = 32'h10;
        #1; vec++; if (bm0.rd_gnt !== 1 || bm1.rd_gnt !== 0) begin err++; $display("FAIL single_gnt: got %b%b want 10", bm0.rd_gnt, bm1.rd_gnt); end
        run_cycle(); idle();
        #1; vec++;
        if (m0_rd_valid !== 1 || m1_rd_valid !== 0 || bm0.rd_data !== init_word(4)) begin
            err++; $display("FAIL single_ret: got %b%b %h want 10 %h", m0_rd_valid, m1_rd_valid, bm0.rd_data, init_word(4));
        end
        run_cycle();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                bm0.rd_req = 1; bm0.rd_addr = 32'($urandom_range(0, 255)) << 2;
                bm1.rd_req = 1; bm1.rd_addr = 32'($urandom_range(0, 255)) << 2;
            end else idle();
            #1;
            if (k < 4) begin
                vec++; if (bm1.rd_gnt !== (k % 2 == 1) || bm0.rd_gnt !== (k % 2 == 0)) begin err++; $display("FAIL alt_gnt%0d: got %b%b want m%0d", k, bm0.rd_gnt, bm1.rd_gnt, k % 2); end
            end
            if (k > 0) begin
                vec++; if (m1_rd_valid !== ((k - 1) % 2 == 1) || m0_rd_valid !== ((k - 1) % 2 == 0)) begin err++; $display("FAIL alt_valid%0d: got %b%b", k, m0_rd_valid, m1_rd_valid); end
            end
            run_cycle();
        end
    endtask

    task automatic test_write_read();
        logic [31:0] w;
        idle();
        bm1.wr_req = 1; bm1.wr_addr = 32'h20; bm1.wr_data = 32'hdeadbeef; bm1.wr_be = 4'b0011;
        bm0.rd_req = 1; bm0.rd_addr = 32'h40;
        #1; vec++; if (bm1.wr_gnt !== 1 || bm0.rd_gnt !== 1) begin err++; $display("FAIL wr_rd_gnt: got %b%b want 11", bm1.wr_gnt, bm0.rd_gnt); end
        run_cycle(); idle();
        #1; vec++; if (m0_rd_valid !== 1 || bm0.rd_data !== init_word(16)) begin err++; $display("FAIL wr_rd_ret: got %b %h want 1 %h", m0_rd_valid, bm0.rd_data, init_word(16)); end
        bm0.rd_req = 1; bm0.rd_addr = 32'h20;
        run_cycle(); idle();
        w = init_word(8);
        #1; vec++; if (bm0.rd_data !== {w[31:16], 16'hbeef}) begin err++; $display("FAIL partial_write: got %h want %h", bm0.rd_data, {w[31:16], 16'hbeef}); end
        run_cycle();
    endtask

    task automatic test_raw();
        logic [31:0] w;
        idle();
        bm1.wr_req = 1; bm1.wr_addr = 32'h80; bm1.wr_data = 32'h000000aa; bm1.wr_be = 4'b0001;
        bm0.rd_req = 1; bm0.rd_addr = 32'h80;
        run_cycle(); idle();
        w = init_word(32);
`ifdef RAM_ARB_RAW_BYPASS_EN
        w[7:0] = 8'haa;
`endif
        #1; vec++; if (m0_rd_valid !== 1 || bm0.rd_data !== w) begin err++; $display("FAIL raw_collision: got %b %h want 1 %h", m0_rd_valid, bm0.rd_data, w); end
        run_cycle();
    endtask

    task automatic test_reset_pending();
        idle(); bm1.rd_req = 1; bm1.rd_addr = 32'h30;
        run_cycle(); idle(); rst = 1;
        #1; vec++; if (m1_rd_valid !== 0) begin err++; $display("FAIL rst_pend_valid: got %b want 0", m1_rd_valid); end
        run_cycle(); rst = 0;
        #1; vec++; if (m0_rd_valid !== 0 || m1_rd_valid !== 0) begin err++; $display("FAIL post_rst_valid: got %b%b want 00", m0_rd_valid, m1_rd_valid); end
        run_cycle();
        bm0.rd_req = 1; bm0.rd_addr = 32'h44; bm1.rd_req = 1; bm1.rd_addr = 32'h48;
        bm0.wr_req = 1; bm0.wr_addr = 32'h50; bm0.wr_be = 4'hf; bm1.wr_req = 1; bm1.wr_addr = 32'h54; bm1.wr_be = 4'hf;
        #1; vec++; if (bm0.rd_gnt !== 1 || bm1.rd_gnt !== 0 || bm0.wr_gnt !== 1 || bm1.wr_gnt !== 0) begin err++; $display("FAIL post_rst_tie: got rd %b%b wr %b%b want m0", bm0.rd_gnt, bm1.rd_gnt, bm0.wr_gnt, bm1.wr_gnt); end
        run_cycle(); idle(); run_cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bm0.rd_req = ($urandom_range(0, 3) != 0); bm0.rd_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            bm1.rd_req = ($urandom_range(0, 3) != 0); bm1.rd_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            bm0.wr_req = ($urandom_range(0, 2) == 0); bm0.wr_addr = 32'($urandom_range(0, 15)) << 2;
            bm0.wr_data = $urandom; bm0.wr_be = 4'($urandom);
            bm1.wr_req = ($urandom_range(0, 2) == 0); bm1.wr_addr = 32'($urandom_range(0, 15)) << 2;
            bm1.wr_data = $urandom; bm1.wr_be = 4'($urandom);
            run_cycle();
        end
        idle(); run_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i] <= init_word(i);
            mem[i] = init_word(i);
        end
        rst = 1;
        idle();
        @(negedge clk);
        test_reset();
        test_single_read();
        test_alternate();
        test_write_read();
        test_raw();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-read/single-write RAM slave (`dualport_bus`) between the instruction-fetch unit (m0) and the load/store unit (m1). The read and write channels are arbitrated independently with round-robin fairness. The block tracks read ownership so that each requester receives a one-cycle-later valid strobe for its own data. It sits between the core's two memory masters and the byte-lane RAM bus wrapper.

## Interface
Parameters:
- `AW`, 32: address width carried on all buses.
- `DW`, 32: data width; byte enables are `DW/8` wide.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0`  modport `dualport_bus.slave`  —  fetch requester (`rd_req`, `rd_addr`, `rd_gnt`, `rd_data`, `wr_req`, `wr_addr`, `wr_data`, `wr_be`, `wr_gnt`).
- `m1`  modport `dualport_bus.slave`  —  load/store requester, same fields.
- `s`  modport `dualport_bus.master`  —  downstream RAM.
- `m0_rd_valid`  out  1  `m0.rd_data` holds m0's read result this cycle.
- `m1_rd_valid`  out  1  `m1.rd_data` holds m1's read result this cycle.

## Operation
- Read channel:
  - `s.rd_req = m0.rd_req | m1.rd_req`.
  - The winner's address drives `s.rd_addr`.
  - The winner alone sees `rd_gnt = 1`; the loser sees `rd_gnt = 0` and must hold its request.
- Read arbitration:
  - One requester: that requester wins.
  - Both requesting: the one not granted last time wins.
  - Pointer `rd_last` updates only on a granted read.
- Write channel:
  - Identical scheme with its own pointer `wr_last`.
  - `s.wr_addr`, `s.wr_data` and `s.wr_be` are taken from the winner.
- Read return:
  - On a granted read, register `rd_pend = 1` and `rd_owner = winner`.
  - Next cycle, `s.rd_data` is broadcast to both `m0.rd_data` and `m1.rd_data`.
  - `mX_rd_valid = rd_pend & (rd_owner == X)`.
- Back-to-back reads: a new grant may issue in the same cycle the previous data returns, so full throughput is one read per cycle.
- Read/write independence: a read and a write may be granted in the same cycle, to the same or different requesters.
- No-request cycles: `s.rd_req` and `s.wr_req` are 0 and both pointers hold.

## Timing
- Grants are combinational, with zero latency from request, matching the slave's immediate grant.
- Read data latency: exactly 1 cycle after the grant cycle.
- Reset values:
  - `rd_pend = 0`, so `m0_rd_valid = m1_rd_valid = 0`.
  - `rd_last = wr_last = 1`, so m0 wins the first tie on each channel.
- Reset asserted with a read outstanding: the pending read is discarded and no valid is issued after reset.
- Grants while `rst = 1` are don't-care; the downstream RAM is not reset by this block.
- Address width: addresses pass unmodified (`AW` bits); the slave performs word decoding.

## Configuration
- Macro `RAM_ARB_RAW_BYPASS_EN`:
  - Defined: when a granted read and a granted write target the same word (`rd_addr[AW-1:2] == wr_addr[AW-1:2]`) in the same cycle, register the write data and byte enables. Next cycle, each returned byte whose `wr_be` bit was set is replaced by the written byte, so the read observes new data.
  - Undefined: no bypass; the returned data is whatever the RAM provides for a same-cycle read/write collision (old data).

## Test plan
- Reset, then idle → both `rd_valid` = 0, `s.rd_req = s.wr_req = 0`.
- m0 alone reads `0x10` in cycle N → `m0.rd_gnt = 1` in N; `m0_rd_valid = 1` in N+1 with RAM word at `0x10`; `m1_rd_valid` stays 0.
- m0 and m1 both hold read requests for 4 cycles → grants alternate m0, m1, m0, m1; valids follow one cycle later with matching owner.
- m1 writes `0xDEADBEEF` with `wr_be = 4'b0011` to `0x20` while m0 reads `0x40` in the same cycle → both granted; next cycle m0 gets its data, and a later read of `0x20` returns the original upper half with `0xBEEF` in the low half.
- Same-cycle m1 write of `0x000000AA` (`be = 4'b0001`) and m0 read at `0x80` → with `RAM_ARB_RAW_BYPASS_EN`, `m0.rd_data[7:0] = 0xAA` next cycle; without it, the old byte is returned.
- Grant m1 read at cycle N, assert `rst` at N+1 → no `m1_rd_valid` in N+1 or after; the first tie after reset goes to m0.
